// File: rtl/ebi_link_master.sv
// EBI link master: queues L2 line requests, serialises them onto the half-duplex
// EBI pad bus, waits for a response header with timeout/retry, deserialises read
// data and hands completions back to the L2 side in request order.
`default_nettype none

module ebi_link_master #(
    parameter int unsigned EBI_WIDTH   = 16,
    parameter int unsigned PADDR_WIDTH = 32,
    parameter int unsigned LINE_WIDTH  = 512,
    parameter int unsigned ID_WIDTH    = 2,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned TURNAROUND  = 2,
    parameter int unsigned TIMEOUT     = 64,
    parameter int unsigned MAX_RETRY   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [ID_WIDTH-1:0]    req_id,
    input  logic [PADDR_WIDTH-1:0] req_addr,
    input  logic [LINE_WIDTH-1:0]  req_data,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_WIDTH-1:0]    rsp_id,
    output logic                   rsp_write,
    output logic                   rsp_err,
    output logic [LINE_WIDTH-1:0]  rsp_data,
    input  logic [EBI_WIDTH-1:0]   ebi_i,
    output logic [EBI_WIDTH-1:0]   ebi_o,
    output logic [EBI_WIDTH-1:0]   ebi_oen,
    output logic                   busy
);

    localparam int unsigned ADDR_BEATS = (PADDR_WIDTH + EBI_WIDTH - 1) / EBI_WIDTH;
    localparam int unsigned DATA_BEATS = LINE_WIDTH / EBI_WIDTH;
    localparam int unsigned ADDR_EXT_W = ADDR_BEATS * EBI_WIDTH;
    localparam int unsigned RD_BEATS   = 1 + ADDR_BEATS;
    localparam int unsigned WR_BEATS   = 1 + ADDR_BEATS + DATA_BEATS;
    localparam int unsigned CNT_MAX_A  = (TIMEOUT > WR_BEATS) ? TIMEOUT : WR_BEATS;
    localparam int unsigned CNT_MAX    = (CNT_MAX_A > TURNAROUND) ? CNT_MAX_A : TURNAROUND;
    localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);
    localparam int unsigned PTR_W      = $clog2(DEPTH);
    localparam int unsigned LVL_W      = $clog2(DEPTH + 1);
    localparam int unsigned RETRY_W    = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    typedef struct packed {
        logic                   write;
        logic [ID_WIDTH-1:0]    id;
        logic [PADDR_WIDTH-1:0] addr;
        logic [LINE_WIDTH-1:0]  data;
    } req_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TURN,
        S_SEND,
        S_WAIT,
        S_RECV,
        S_RESP
    } state_t;

    req_t                 q_mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [LVL_W-1:0]     level_q;
    logic [LVL_W-1:0]     level_d;
    logic                 push;
    logic                 pop;
    req_t                 head;

    state_t               state_q;
    state_t               state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    logic [RETRY_W-1:0]   retry_q;
    logic [RETRY_W-1:0]   retry_d;
    logic                 err_q;
    logic                 err_d;
    logic [CNT_W-1:0]     last_beat;

    logic                 hdr_marker;
    logic [3:0]           hdr_status;
    logic [ID_WIDTH-1:0]  hdr_id;

    logic [CNT_W-1:0]     tx_idx;
    logic [ADDR_EXT_W-1:0] addr_ext;
    logic [EBI_WIDTH-1:0] tx_word;

    assign push       = req_valid && req_ready;
    assign pop        = rsp_valid && rsp_ready;
    assign head       = q_mem[rd_ptr_q];
    assign hdr_marker = ebi_i[EBI_WIDTH-1];
    assign hdr_status = ebi_i[3:0];
    assign hdr_id     = ebi_i[4 +: ID_WIDTH];
    assign last_beat  = head.write ? CNT_W'(WR_BEATS - 1) : CNT_W'(RD_BEATS - 1);
    assign addr_ext   = ADDR_EXT_W'(head.addr);

    // Queue occupancy after this cycle's push/pop
    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Queue storage; contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (push) begin
            q_mem[wr_ptr_q] <= '{write: req_write, id: req_id, addr: req_addr, data: req_data};
        end
    end

    // Queue pointers and occupancy; the head stays in place until its completion is taken
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            level_q <= level_d;
        end
    end

    // Next-state logic for the link sequencer
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (level_q != '0) begin
                    state_d = S_TURN;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            S_TURN: begin
                if (cnt_q == CNT_W'(TURNAROUND - 1)) begin
                    state_d = S_SEND;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SEND: begin
                if (cnt_q == last_beat) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT: begin
                // A header in the final timeout cycle still wins over a retry
                if (hdr_marker) begin
                    err_d = (hdr_status != 4'd0) || (hdr_id != head.id);
                    cnt_d = '0;
                    if (!head.write && (hdr_status == 4'd0)) begin
                        state_d = S_RECV;
                    end else begin
                        state_d = S_RESP;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    cnt_d = '0;
                    if (retry_q < RETRY_W'(MAX_RETRY)) begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = S_TURN;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RECV: begin
                if (cnt_q == CNT_W'(DATA_BEATS - 1)) begin
                    state_d = S_RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                    retry_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign tx_idx = (state_d == S_SEND) ? cnt_d : '0;

    // Beat to drive next: header, address beats low first, then data beats low first
    always_comb begin
        tx_word = '0;
        if (tx_idx == '0) begin
            tx_word[EBI_WIDTH-1]     = 1'b1;
            tx_word[3:0]             = {3'b000, head.write};
            tx_word[4 +: ID_WIDTH]   = head.id;
        end else if (tx_idx <= CNT_W'(ADDR_BEATS)) begin
            tx_word = addr_ext[(32'(tx_idx) - 32'd1) * EBI_WIDTH +: EBI_WIDTH];
        end else begin
            tx_word = head.data[(32'(tx_idx) - 32'd1 - ADDR_BEATS) * EBI_WIDTH +: EBI_WIDTH];
        end
    end

    // Sequencer state and registered outputs, all taken from the next-state view
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            retry_q   <= '0;
            err_q     <= 1'b0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_write <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
            ebi_o     <= '0;
            ebi_oen   <= '1;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            err_q     <= err_d;
            req_ready <= (level_d != LVL_W'(DEPTH));
            rsp_valid <= (state_d == S_RESP);
            rsp_id    <= (state_d == S_RESP) ? head.id : '0;
            rsp_write <= (state_d == S_RESP) && head.write;
            rsp_err   <= (state_d == S_RESP) && err_d;
            ebi_o     <= (state_d == S_SEND) ? tx_word : '0;
            ebi_oen   <= (state_d == S_SEND) ? '0 : '1;
            busy      <= (state_d != S_IDLE) || (level_d != '0);
            // Read data lands only for a clean header; mismatched reads drain silently
            if (pop) begin
                rsp_data <= '0;
            end else if ((state_q == S_RECV) && !err_q) begin
                rsp_data[32'(cnt_q) * EBI_WIDTH +: EBI_WIDTH] <= ebi_i;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ebi_link_master.sv
// Directed bench for ebi_link_master with default parameters.
`timescale 1ns/1ps

module tb_ebi_link_master;

    localparam int unsigned LW = 512;

    logic           clk = 1'b0;
    logic           rst;
    logic           req_valid;
    logic           req_ready;
    logic           req_write;
    logic [1:0]     req_id;
    logic [31:0]    req_addr;
    logic [LW-1:0]  req_data;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_id;
    logic           rsp_write;
    logic           rsp_err;
    logic [LW-1:0]  rsp_data;
    logic [15:0]    ebi_i;
    logic [15:0]    ebi_o;
    logic [15:0]    ebi_oen;
    logic           busy;

    int total = 0;
    int bad   = 0;

    logic [LW-1:0] line_cnt;
    logic [LW-1:0] line_a0;
    logic [LW-1:0] line_55;
    logic [LW-1:0] line_12;
    int            n;

    ebi_link_master dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_id    (req_id),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_write (rsp_write),
        .rsp_err   (rsp_err),
        .rsp_data  (rsp_data),
        .ebi_i     (ebi_i),
        .ebi_o     (ebi_o),
        .ebi_oen   (ebi_oen),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_oen(input logic [15:0] val, input string tag, output int cnt);
        cnt = 0;
        while (ebi_oen !== val && cnt < 300) begin
            step();
            cnt++;
        end
        chk(tag, ebi_oen, val);
    endtask

    task automatic wait_rsp(input string tag, output int cnt);
        cnt = 0;
        while (rsp_valid !== 1'b1 && cnt < 300) begin
            step();
            cnt++;
        end
        chk(tag, rsp_valid, 1);
    endtask

    task automatic push(input logic wr, input logic [1:0] id, input logic [31:0] addr,
                        input logic [LW-1:0] data);
        req_valid = 1'b1;
        req_write = wr;
        req_id    = id;
        req_addr  = addr;
        req_data  = data;
        step();
        req_valid = 1'b0;
    endtask

    // Expects to be called at the header beat; ends on the first released cycle
    task automatic check_frame(input string tag, input logic wr, input logic [1:0] id,
                               input logic [31:0] addr, input logic [LW-1:0] data);
        int nb;
        logic [15:0] exp_w;
        nb = wr ? 35 : 3;
        for (int i = 0; i < nb; i++) begin
            if (i == 0)      exp_w = 16'h8000 | {10'd0, id, 3'b000, wr};
            else if (i == 1) exp_w = addr[15:0];
            else if (i == 2) exp_w = addr[31:16];
            else             exp_w = data[(i - 3) * 16 +: 16];
            chk($sformatf("%s_beat%0d", tag, i), {ebi_oen, ebi_o}, {16'h0000, exp_w});
            step();
        end
        chk({tag, "_release"}, ebi_oen, 16'hFFFF);
    endtask

    task automatic inject(input logic [15:0] hdr, input int nbeats, input logic [15:0] base);
        ebi_i = hdr;
        step();
        for (int k = 0; k < nbeats; k++) begin
            ebi_i = base + 16'(k);
            step();
        end
        ebi_i = '0;
    endtask

    task automatic handshake(input string tag);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk({tag, "_popped"}, rsp_valid, 0);
    endtask

    task automatic serve_write(input string tag, input logic [1:0] id, input logic [31:0] addr,
                               input bit do_hs);
        int c;
        wait_oen(16'h0000, {tag, "_start"}, c);
        chk({tag, "_hdr"}, ebi_o, {8'h80, 2'b00, id, 4'h1});
        step();
        chk({tag, "_addr"}, ebi_o, addr[15:0]);
        wait_oen(16'hFFFF, {tag, "_end"}, c);
        inject({8'h80, 2'b00, id, 4'h0}, 0, 16'h0);
        chk({tag, "_valid"}, rsp_valid, 1);
        chk({tag, "_id"}, rsp_id, id);
        chk({tag, "_err"}, rsp_err, 0);
        if (do_hs) handshake(tag);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_id    = '0;
        req_addr  = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        ebi_i     = '0;
        for (int k = 0; k < 32; k++) begin
            line_cnt[k * 16 +: 16] = 16'(k);
            line_a0[k * 16 +: 16]  = 16'hA000 + 16'(k);
            line_55[k * 16 +: 16]  = 16'h5500 + 16'(k);
            line_12[k * 16 +: 16]  = 16'h1200 + 16'(k);
        end

        // Reset values
        repeat (3) step();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_write", rsp_write, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_ebi_o", ebi_o, 0);
        chk("rst_ebi_oen", ebi_oen, 16'hFFFF);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        step();

        // Read id=1: one IDLE cycle to see the queue, then two turnaround cycles
        push(1'b0, 2'd1, 32'h8000_0040, '0);
        chk("rd_busy", busy, 1);
        wait_oen(16'h0000, "rd_start", n);
        chk("rd_lead_cycles", n, 3);
        check_frame("rd", 1'b0, 2'd1, 32'h8000_0040, '0);
        inject(16'h8010, 32, 16'h0000);
        chk("rd_valid", rsp_valid, 1);
        chk("rd_id", rsp_id, 1);
        chk("rd_err", rsp_err, 0);
        chk("rd_write", rsp_write, 0);
        chk("rd_data", rsp_data, line_cnt);
        step();
        chk("rd_hold_valid", rsp_valid, 1);
        chk("rd_hold_data", rsp_data, line_cnt);
        handshake("rd");
        chk("rd_idle_busy", busy, 0);

        // Write id=2 with 35 driven beats, header-only completion
        push(1'b1, 2'd2, 32'h0000_0100, line_a0);
        wait_oen(16'h0000, "wr_start", n);
        check_frame("wr", 1'b1, 2'd2, 32'h0000_0100, line_a0);
        inject(16'h8020, 0, 16'h0);
        chk("wr_valid", rsp_valid, 1);
        chk("wr_write", rsp_write, 1);
        chk("wr_id", rsp_id, 2);
        chk("wr_err", rsp_err, 0);
        chk("wr_data", rsp_data, 0);
        handshake("wr");

        // Fill the queue with completions held off
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fifo_ready%0d", i), req_ready, 1);
            req_valid = 1'b1;
            req_write = 1'b1;
            req_id    = 2'(i);
            req_addr  = 32'(16 * (i + 1));
            req_data  = '0;
            step();
        end
        chk("fifo_full", req_ready, 0);
        req_id   = 2'd1;
        req_addr = 32'h50;
        serve_write("fifo0", 2'd0, 32'h10, 1'b0);
        chk("fifo_still_full", req_ready, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("fifo0_popped", rsp_valid, 0);
        chk("fifo_no_bypass", req_ready, 1);
        step();
        req_valid = 1'b0;
        chk("fifo_fifth_taken", req_ready, 0);
        serve_write("fifo1", 2'd1, 32'h20, 1'b1);
        serve_write("fifo2", 2'd2, 32'h30, 1'b1);
        serve_write("fifo3", 2'd3, 32'h40, 1'b1);
        serve_write("fifo4", 2'd1, 32'h50, 1'b1);
        chk("fifo_drained", busy, 0);

        // No response: three attempts, then an error completion
        push(1'b0, 2'd1, 32'h0000_0200, '0);
        wait_oen(16'h0000, "to_start", n);
        check_frame("to_a1", 1'b0, 2'd1, 32'h0000_0200, '0);
        wait_oen(16'h0000, "to_retry1", n);
        chk("to_gap1", n, 66);
        check_frame("to_a2", 1'b0, 2'd1, 32'h0000_0200, '0);
        wait_oen(16'h0000, "to_retry2", n);
        chk("to_gap2", n, 66);
        check_frame("to_a3", 1'b0, 2'd1, 32'h0000_0200, '0);
        wait_rsp("to_rsp", n);
        chk("to_rsp_wait", n, 64);
        chk("to_oen_idle", ebi_oen, 16'hFFFF);
        chk("to_err", rsp_err, 1);
        chk("to_id", rsp_id, 1);
        chk("to_data", rsp_data, 0);
        handshake("to");

        // Response to the second attempt completes cleanly
        push(1'b0, 2'd1, 32'h0000_0300, '0);
        wait_oen(16'h0000, "rt_start", n);
        check_frame("rt_a1", 1'b0, 2'd1, 32'h0000_0300, '0);
        wait_oen(16'h0000, "rt_retry1", n);
        chk("rt_gap1", n, 66);
        check_frame("rt_a2", 1'b0, 2'd1, 32'h0000_0300, '0);
        inject(16'h8010, 32, 16'h5500);
        chk("rt_valid", rsp_valid, 1);
        chk("rt_err", rsp_err, 0);
        chk("rt_data", rsp_data, line_55);
        handshake("rt");
        repeat (70) step();
        chk("rt_no_third_oen", ebi_oen, 16'hFFFF);
        chk("rt_no_third_busy", busy, 0);

        // Marker in the cycle the timeout expires is taken as the response
        push(1'b1, 2'd3, 32'h0000_0400, '0);
        wait_oen(16'h0000, "edge_start", n);
        check_frame("edge", 1'b1, 2'd3, 32'h0000_0400, '0);
        repeat (63) step();
        chk("edge_no_retry_yet", ebi_oen, 16'hFFFF);
        inject(16'h8030, 0, 16'h0);
        chk("edge_valid", rsp_valid, 1);
        chk("edge_err", rsp_err, 0);
        chk("edge_id", rsp_id, 3);
        handshake("edge");
        chk("edge_idle", busy, 0);

        // Device status error on a write
        push(1'b1, 2'd1, 32'h0000_0500, '0);
        wait_oen(16'h0000, "sw_start", n);
        check_frame("sw", 1'b1, 2'd1, 32'h0000_0500, '0);
        inject(16'h8011, 0, 16'h0);
        chk("sw_valid", rsp_valid, 1);
        chk("sw_err", rsp_err, 1);
        chk("sw_write", rsp_write, 1);
        chk("sw_data", rsp_data, 0);
        handshake("sw");

        // Device status error on a read: no data beats follow
        push(1'b0, 2'd1, 32'h0000_0510, '0);
        wait_oen(16'h0000, "sr_start", n);
        check_frame("sr", 1'b0, 2'd1, 32'h0000_0510, '0);
        inject(16'h8011, 0, 16'h0);
        chk("sr_valid", rsp_valid, 1);
        chk("sr_err", rsp_err, 1);
        chk("sr_data", rsp_data, 0);
        handshake("sr");

        // ID mismatch on a read drains 32 beats, then reports an error with no data
        push(1'b0, 2'd1, 32'h0000_0520, '0);
        wait_oen(16'h0000, "mm_start", n);
        check_frame("mm", 1'b0, 2'd1, 32'h0000_0520, '0);
        inject(16'h8030, 31, 16'h7700);
        chk("mm_not_yet", rsp_valid, 0);
        ebi_i = 16'h771F;
        step();
        ebi_i = '0;
        chk("mm_valid", rsp_valid, 1);
        chk("mm_err", rsp_err, 1);
        chk("mm_id", rsp_id, 1);
        chk("mm_data", rsp_data, 0);
        handshake("mm");

        // Reset during write beat 10 drops the frame and the queued request
        push(1'b1, 2'd2, 32'h0000_0600, line_a0);
        push(1'b1, 2'd3, 32'h0000_0610, '0);
        wait_oen(16'h0000, "mr_start", n);
        repeat (10) step();
        chk("mr_beat10", {ebi_oen, ebi_o}, {16'h0000, 16'hA007});
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr_oen", ebi_oen, 16'hFFFF);
        chk("mr_ebi_o", ebi_o, 0);
        chk("mr_rsp_valid", rsp_valid, 0);
        chk("mr_req_ready", req_ready, 1);
        chk("mr_busy", busy, 0);
        repeat (20) step();
        chk("mr_queue_dropped", ebi_oen, 16'hFFFF);
        push(1'b0, 2'd0, 32'h0000_0700, '0);
        wait_oen(16'h0000, "pr_start", n);
        check_frame("pr", 1'b0, 2'd0, 32'h0000_0700, '0);
        inject(16'h8000, 32, 16'h1200);
        chk("pr_valid", rsp_valid, 1);
        chk("pr_err", rsp_err, 0);
        chk("pr_id", rsp_id, 0);
        chk("pr_data", rsp_data, line_12);
        handshake("pr");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ebi_link_master.md
Name: ebi_link_master

Overview:
- Next-generation on-chip EBI master: a parametrised, queued request engine that serialises read/write line requests onto a half-duplex EBI pad bus.
- Deserialises responses, enforces a response timeout with bounded retry, and returns completions to the L2 side.
- Sits between the L2 request/response interfaces and the GPIO EBI pins.
- Generalises the single-buffer master: configurable bus/line/address/ID widths, a multi-entry request queue, programmable turnaround, and timeout/retry/error reporting.

Parameters:
EBI_WIDTH, 16, pad bus width; must be >= 5+ID_WIDTH.
PADDR_WIDTH, 32, physical address width.
LINE_WIDTH, 512, cacheline width; must be a multiple of EBI_WIDTH.
ID_WIDTH, 2, transaction ID width.
DEPTH, 4, request queue entries (power of 2, >= 2).
TURNAROUND, 2, idle bus cycles (ebi_oen all-1) before every transmit.
TIMEOUT, 64, WAIT cycles without a response header before a retry.
MAX_RETRY, 2, retries before an error completion.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request valid
req_ready  out  1  queue not full
req_write  in  1  1=write line, 0=read line
req_id  in  ID_WIDTH  transaction ID
req_addr  in  PADDR_WIDTH  line address
req_data  in  LINE_WIDTH  write data (ignored for reads)
rsp_valid  out  1  completion valid
rsp_ready  in  1  completion accepted
rsp_id  out  ID_WIDTH  ID of completed request
rsp_write  out  1  completion type
rsp_err  out  1  1=device error, ID mismatch or retries exhausted
rsp_data  out  LINE_WIDTH  read data (0 for writes and errors)
ebi_i  in  EBI_WIDTH  pad input
ebi_o  out  EBI_WIDTH  pad output
ebi_oen  out  EBI_WIDTH  per-bit output enable, 0=drive
busy  out  1  FSM not in IDLE or queue not empty

Behaviour:
- Reset: flops clear in the same edge. Queue empty; FSM=IDLE; retry_cnt=0. Outputs: req_ready=1, rsp_valid=0, rsp_err=0, rsp_id=0, rsp_write=0, rsp_data=0, ebi_o=0, ebi_oen=all-1, busy=0.
- Reset mid-frame: the bus is released the cycle after rst is sampled; in-flight and queued requests are dropped.
- Derived: ADDR_BEATS=ceil(PADDR_WIDTH/EBI_WIDTH); DATA_BEATS=LINE_WIDTH/EBI_WIDTH.
- Header beat layout: bit[EBI_WIDTH-1]=1 (marker), [3:0]=opcode/status, [4+:ID_WIDTH]=id, all other bits 0.
- Request frame:
  - Header opcode: 0=read, 1=write.
  - Then ADDR_BEATS address beats, low beat first, zero-extended.
  - Write frames append DATA_BEATS data beats, low beat first.
- Queue:
  - FIFO push on req_valid&&req_ready; req_ready=!full, with no same-cycle bypass when full.
  - Head entry is the in-flight request; it is popped on rsp_valid&&rsp_ready.
  - Pointers wrap modulo DEPTH.
- FSM:
  - IDLE: queue non-empty -> TURN.
  - TURN: drive ebi_oen=all-1 for exactly TURNAROUND cycles -> SEND.
  - SEND: one beat per cycle, ebi_o registered, ebi_oen=all-0 for exactly 1+ADDR_BEATS (read) or 1+ADDR_BEATS+DATA_BEATS (write) consecutive cycles -> WAIT. ebi_oen returns to all-1 the cycle after the last beat.
  - WAIT: the timeout counter increments each cycle. If ebi_i[EBI_WIDTH-1]=1, latch the header -> RECV for a read with status 0, else -> RESP.
    - Counter reaches TIMEOUT with retry_cnt<MAX_RETRY: retry_cnt++ -> TURN, full frame resent.
    - Counter reaches TIMEOUT with retry_cnt==MAX_RETRY: -> RESP with rsp_err=1.
  - RECV: capture DATA_BEATS beats, one per cycle, into rsp_data low beat first -> RESP.
  - RESP: rsp_valid=1 held until rsp_ready; on the handshake, pop, retry_cnt=0 -> IDLE.
- Response handling:
  - Status!=0 or header id!=head id gives rsp_err=1.
  - An ID-mismatched read still consumes DATA_BEATS beats, but rsp_data=0.
  - A device status error on a read transfers no data beats.
  - Write completion is header-only.
- rsp outputs are stable while rsp_valid=1 && !rsp_ready.
- ebi_i is ignored outside WAIT/RECV.
- A marker arriving in the same cycle the counter reaches TIMEOUT is accepted as the response; no retry occurs.

Test Plan:
- Defaults; read id=1, addr=0x8000_0040 -> 2 idle cycles, then ebi_o=0x8010,0x0040,0x8000 with oen=0 for 3 cycles. Inject header 0x8010 + 32 beats 0x0000..0x001F -> rsp_valid, rsp_id=1, rsp_err=0, rsp_data beat k=k.
- Write id=2, addr=0x100, data beat k=0xA000+k -> 35 driven beats: 0x8021,0x0100,0x0000,0xA000..0xA01F. Header 0x8020 -> rsp_write=1, rsp_err=0, rsp_data=0.
- Push 5 requests back-to-back with rsp_ready=0 -> req_ready=0 after the 4th; 5th accepted only after the first rsp handshake; completions in FIFO order.
- Read with no response -> frame sent 3 times, each after 64 WAIT cycles plus turnaround; then rsp_err=1, rsp_data=0. A response to the 2nd attempt -> rsp_err=0 and no 3rd attempt.
- Header with status 1, or id=3 while head id=1 -> rsp_err=1; mismatched read consumes 32 beats before rsp_valid.
- Assert rst during write beat 10 -> next cycle ebi_oen=0xFFFF, rsp_valid=0, req_ready=1; a following read completes normally.
